rs_encoder_sp: RTL and testbench
================================

Name: rs_encoder_sp

Overview:
- Parametrised systematic Reed-Solomon encoder over GF(2^8), field poly p(x)=x^8+x^4+x^3+x^2+1 (0x11D).
- Generator g(x)=(x+α^0)(x+α^1)…(x+α^(2T-1)), α=0x02.
- Accepts shortened blocks of variable length under valid/ready flow control, passes information bytes through, then appends parity.
- Sits between the randomizer and the convolutional encoder in the WiMAX OFDM transmit chain.

Parameters:
- T, 8, maximum correctable symbols; parity register depth 2T; legal range 1..16.
- KMAX, 255-2*T, maximum information bytes per block.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- in_bits  input  8  information byte
- in_valid  input  1  in_bits valid
- in_last  input  1  marks final information byte of block
- in_ready  output  1  encoder accepts a byte this cycle
- t_sel  input  5  parity symbols/2 for next block (T'); see Optional Feature
- out_bits  output  8  codeword byte
- out_valid  output  1  out_bits valid
- out_last  output  1  final byte of codeword
- out_ready  input  1  downstream accepts a byte this cycle
- len_err  output  1  one-cycle pulse: block truncated at KMAX

Behaviour:
- One clock domain. Reset is synchronous and active-high on reset, sampled at the rising edge of clk.
- Reset values:
  - out_bits=0, out_valid=0, out_last=0, len_err=0.
  - Parity regs b[0..2T-1]=0, byte counter=0, state=IDLE.
  - in_ready=0 while reset is high.
  - Reset mid-block discards the block; nothing is flushed.
- Transfer rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Output register: single stage. It is free when !out_valid or out_ready.
- in_ready = (state!=PARITY) & output register free.
- States:
  - IDLE: no block open. First accepted byte goes to DATA, or straight to PARITY if in_last. T'=t_sel is latched on that byte.
  - DATA, on each accepted byte d:
    - fb = d ^ b[2T-1]
    - b[i] <= b[i-1] ^ g_i·fb for i=2T-1..1
    - b[0] <= g_0·fb
    - out_bits <= d, out_valid <= 1, counter +1
    - latency input to output: 1 cycle
  - Leaving DATA: on in_last, go to PARITY.
  - Forced truncation: on the KMAX-th byte without in_last, the byte is treated as last, len_err pulses 1 cycle, and the next input byte starts a new block.
  - PARITY: each cycle the output register is free:
    - out_bits <= b[2T-1], regs shift up by one, b[0]<=0.
    - Bytes go out highest-degree first. Exactly 2T' bytes are emitted.
    - out_last=1 with the final byte.
    - On that load: clear all b, clear counter, go to IDLE. in_ready can assert the following cycle.
- Generator coefficients g_i are computed at elaboration by a constant function. Multipliers are constant-coefficient XOR networks; no multiply by variable operands.
- Backpressure: out_valid, out_bits and out_last hold stable while out_valid & !out_ready.
- Bubbles on in_valid are allowed and add no state change.
- Codeword length is K+2T' with K in 1..KMAX. K=0 is not possible (a block opens on a byte).

Optional Feature:
- Macro: RS_PUNCTURE_EN.
- Defined:
  - T' = t_sel, latched per block.
  - t_sel=0 means no parity: block ends with the last info byte carrying out_last, no PARITY state.
  - t_sel>T saturates to T.
  - Only the first 2T' parity bytes (highest degree) are emitted; the remaining registers are discarded by the clear.
- Undefined: t_sel ignored, T'=T always, no puncturing logic synthesised.

Test Plan:
- T=1, single byte 0x01 with in_last, out_ready=1 -> out 0x01, 0x03, 0x02 on consecutive cycles, out_last on 0x02.
- T=1, bytes 0x01, 0x00 (last) -> out 0x01, 0x00, 0x07, 0x06, out_last on 0x06.
- T=8, single byte 0x01 -> 16 parity bytes equal g_15..g_0, g_0=α^120. 239 zero bytes -> 16 zero parity bytes.
- T=8, 240 bytes with no in_last -> len_err pulses on byte 239, parity follows, byte 240 opens a new block.
- Random out_ready toggling plus in_valid gaps -> byte stream identical to the no-stall run. No output change while stalled; in_ready=0 throughout PARITY.
- RS_PUNCTURE_EN, T=8, t_sel=4, byte 0x01 -> parity = g_15..g_8 only (8 bytes). t_sel=0 -> out_last on the info byte. Reset asserted mid-PARITY -> out_valid=0 next cycle, next block encodes correctly.

Source files
------------

// File: rtl/rs_encoder_sp.sv
// Systematic Reed-Solomon encoder over GF(2^8) (p(x)=0x11D, roots alpha^0..alpha^(2T-1)).
// Define RS_PUNCTURE_EN to emit 2*t_sel parity bytes per block (saturated at 2T) instead of always 2T.
module rs_encoder_sp #(
  parameter int T    = 8,
  parameter int KMAX = 255 - 2 * T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_bits,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [4:0] t_sel,
  output logic [7:0] out_bits,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       len_err
);
  localparam int NP = 2 * T;
  localparam int BW = NP * 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [7:0] KLAST    = 8'(KMAX - 1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // Coefficients g_0..g_(2T-1) of the monic generator; g_2T=1 is implicit in the feedback.
  function automatic logic [BW-1:0] gen_poly();
    logic [(NP+1)*8-1:0] g;
    logic [7:0]          root;
    g      = '0;
    g[7:0] = 8'h01;
    root   = 8'h01;
    for (int unsigned j = 0; j < NP; j++) begin
      for (int unsigned i = j + 1; i > 0; i--)
        g[i*8 +: 8] = g[(i-1)*8 +: 8] ^ gf_mul(g[i*8 +: 8], root);
      g[7:0] = gf_mul(g[7:0], root);
      root   = gf_mul(root, 8'h02);
    end
    return g[BW-1:0];
  endfunction

  localparam logic [BW-1:0] GEN = gen_poly();

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [5:0]    pcnt_q, pcnt_d;
  logic [7:0]    out_bits_q, out_bits_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          len_err_q, len_err_d;
  logic          free, accept, trunc;
  logic [7:0]    fb;
  logic [5:0]    np_cur;

`ifdef RS_PUNCTURE_EN
  logic [4:0] tp_q, tp_d, tp_new, tp_cur;
  assign tp_new = (t_sel > 5'(T)) ? 5'(T) : t_sel;
  // The opening byte of a block already uses the freshly selected parity count.
  assign tp_cur = (state_q == S_IDLE) ? tp_new : tp_q;
  assign np_cur = {tp_cur, 1'b0};
  assign tp_d   = (accept && state_q == S_IDLE) ? tp_new : tp_q;

  always_ff @(posedge clk) begin
    if (reset) tp_q <= '0;
    else       tp_q <= tp_d;
  end
`else
  logic unused_t_sel;
  assign unused_t_sel = ^t_sel;
  assign np_cur       = 6'(NP);
`endif

  assign free     = !out_valid_q || out_ready;
  assign in_ready = !reset && (state_q != S_PARITY) && free;
  assign accept   = in_valid && in_ready;
  assign fb       = in_bits ^ b_q[BW-1 -: 8];
  assign trunc    = !in_last && (cnt_q == KLAST);

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    len_err_d   = 1'b0;
    if (free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept) begin
      b_d[7:0] = gf_mul(fb, GEN[7:0]);
      for (int unsigned i = 1; i < NP; i++)
        b_d[i*8 +: 8] = b_q[(i-1)*8 +: 8] ^ gf_mul(fb, GEN[i*8 +: 8]);
      out_bits_d  = in_bits;
      out_valid_d = 1'b1;
      cnt_d       = cnt_q + 8'd1;
      len_err_d   = trunc;
      if (in_last || trunc) begin
        if (np_cur == 6'd0) begin
          out_last_d = 1'b1;
          b_d        = '0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_PARITY;
        end
      end else begin
        state_d = S_DATA;
      end
    end else if (state_q == S_PARITY && free) begin
      out_bits_d  = b_q[BW-1 -: 8];
      out_valid_d = 1'b1;
      b_d         = {b_q[BW-9:0], 8'h00};
      pcnt_d      = pcnt_q + 6'd1;
      if (pcnt_q == np_cur - 6'd1) begin
        out_last_d = 1'b1;
        b_d        = '0;
        cnt_d      = '0;
        pcnt_d     = '0;
        state_d    = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end

  assign out_bits  = out_bits_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign len_err   = len_err_q;
endmodule

// File: tb/tb_rs_encoder_sp.sv
// Scoreboard bench for rs_encoder_sp: T=8 instance with a table-based GF reference, plus a T=1 instance with fixed vectors.
module tb_rs_encoder_sp;
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       par;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_bits, out_bits;
  logic       in_valid, in_last, in_ready, out_valid, out_last, out_ready, len_err;
  logic [4:0] t_sel;
  logic [7:0] in_bits1, out_bits1;
  logic       in_valid1, in_last1, in_ready1, out_valid1, out_last1, len_err1;
  logic       stall_en;

  rs_encoder_sp #(.T(8)) u_dut (
    .clk(clk), .reset(reset), .in_bits(in_bits), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .t_sel(t_sel), .out_bits(out_bits), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .len_err(len_err)
  );

  rs_encoder_sp #(.T(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_bits(in_bits1), .in_valid(in_valid1), .in_last(in_last1),
    .in_ready(in_ready1), .t_sel(5'd1), .out_bits(out_bits1), .out_valid(out_valid1),
    .out_last(out_last1), .out_ready(1'b1), .len_err(len_err1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // GF(2^8) reference via log/antilog tables
  logic [7:0] gexp [0:254];
  int         glog [0:255];
  logic [7:0] gen  [0:16];
  logic [7:0] mpar [0:15];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic init_gf();
    logic [7:0] x;
    logic [7:0] tmp [0:16];
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    for (int i = 0; i <= 16; i++) gen[i] = 8'h00;
    gen[0] = 8'h01;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i <= 16; i++) tmp[i] = 8'h00;
      for (int i = 0; i <= j; i++) begin
        tmp[i+1] = tmp[i+1] ^ gen[i];
        tmp[i]   = tmp[i] ^ gmul(gen[i], gexp[j]);
      end
      for (int i = 0; i <= 16; i++) gen[i] = tmp[i];
    end
  endtask

  task automatic compute_parity(input logic [7:0] msg[$]);
    logic [7:0] r[$];
    logic [7:0] c;
    r = msg;
    for (int j = 0; j < 16; j++) r.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      c = r[i];
      if (c != 8'h00)
        for (int j = 0; j <= 16; j++) r[i+j] = r[i+j] ^ gmul(c, gen[16-j]);
    end
    for (int j = 0; j < 16; j++) mpar[j] = r[msg.size()+j];
  endtask

  function automatic int eff_np(input logic [4:0] ts);
`ifdef RS_PUNCTURE_EN
    return (ts > 5'd8) ? 16 : 2 * int'(ts);
`else
    return 16 + 0 * int'(ts);
`endif
  endfunction

  exp_t exp_q[$];
  exp_t q1[$];

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    logic acc;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_bits = d; in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("in_ready_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic last);
    logic acc;
    in_bits1 = d; in_last1 = last; in_valid1 = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk); acc = in_ready1;
      @(posedge clk); #1;
    end
    if (!acc) check("t1_ready_timeout", 32'(acc), 32'd1);
    in_valid1 = 1'b0; in_last1 = 1'b0;
  endtask

  task automatic run_block(input logic [7:0] msg[$], input int np, input int gapmax, input logic drive_last);
    int k_len;
    k_len = msg.size();
    compute_parity(msg);
    for (int k = 0; k < k_len; k++)
      exp_q.push_back('{data: msg[k], last: (k == k_len - 1) && (np == 0), par: 1'b0});
    for (int j = 0; j < np; j++)
      exp_q.push_back('{data: mpar[j], last: (j == np - 1), par: 1'b1});
    for (int k = 0; k < k_len; k++)
      send_byte(msg[k], drive_last && (k == k_len - 1), (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 5000 && (exp_q.size() != 0 || q1.size() != 0); n++) @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size() + q1.size()), 32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  logic       stalled_prev = 1'b0;
  logic [7:0] prev_bits;
  logic       prev_last;
  int         len_err_cnt = 0;
  logic [7:0] le_byte = 8'hEF;
  exp_t       e, e1;

  always @(negedge clk) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev)
        check("hold", 32'({out_valid, out_last, out_bits}), 32'({1'b1, prev_last, prev_bits}));
      if (exp_q.size() > 0 && exp_q[0].par && !exp_q[0].last)
        check("ready_in_parity", 32'(in_ready), 32'd0);
      if (len_err) begin
        len_err_cnt++;
        check("len_err_byte", 32'({out_valid, out_bits}), 32'({1'b1, le_byte}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", 32'(out_bits), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_bits    = out_bits;
      prev_last    = out_last;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid1) begin
      if (q1.size() == 0) begin
        check("t1_spurious", 32'(out_valid1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("t1_byte", 32'(out_bits1), 32'(e1.data));
        check("t1_last", 32'(out_last1), 32'(e1.last));
      end
    end
  end

  logic [7:0] m[$];
  int         len;

  initial begin
    init_gf();
    reset = 1'b1; stall_en = 1'b0; t_sel = 5'd8;
    in_bits = '0; in_valid = 1'b0; in_last = 1'b0;
    in_bits1 = '0; in_valid1 = 1'b0; in_last1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'({out_valid, out_last, len_err, out_bits}), 32'd0);
    check("rst_in_ready", 32'({in_ready, in_ready1}), 32'd0);
    check("rst_out1", 32'({out_valid1, out_last1, len_err1}), 32'd0);
    reset = 1'b0;

    // T=1 fixed vectors
    q1.push_back('{data: 8'h01, last: 1'b0, par: 1'b0});
    q1.push_back('{data: 8'h03, last: 1'b0, par: 1'b1});
    q1.push_back('{data: 8'h02, last: 1'b1, par: 1'b1});
    q1.push_back('{data: 8'h01, last: 1'b0, par: 1'b0});
    q1.push_back('{data: 8'h00, last: 1'b0, par: 1'b0});
    q1.push_back('{data: 8'h07, last: 1'b0, par: 1'b1});
    q1.push_back('{data: 8'h06, last: 1'b1, par: 1'b1});
    send1(8'h01, 1'b1);
    check("t1_latency", 32'({out_valid1, out_bits1}), 32'({1'b1, 8'h01}));
    send1(8'h01, 1'b0);
    send1(8'h00, 1'b1);

    // T=8 single 0x01: parity is g15..g0
    m.delete(); m.push_back(8'h01);
    run_block(m, 16, 0, 1'b1);
    // 239 zero bytes: all-zero parity, no truncation
    m.delete();
    for (int k = 0; k < 239; k++) m.push_back(8'h00);
    run_block(m, 16, 0, 1'b1);
    wait_drain("drain_basic");

    // 240 bytes, no in_last: truncation at 239, byte 240 opens a new block
    m.delete();
    for (int k = 0; k < 239; k++) m.push_back(8'(k + 1));
    run_block(m, 16, 0, 1'b0);
    m.delete(); m.push_back(8'h01);
    run_block(m, 16, 0, 1'b1);
    wait_drain("drain_trunc");
    check("len_err_cnt", 32'(len_err_cnt), 32'd1);

    // Random backpressure and input bubbles
    stall_en = 1'b1;
    for (int b = 0; b < 12; b++) begin
      len = int'($urandom_range(1, 40));
      m.delete();
      for (int k = 0; k < len; k++) m.push_back(8'($urandom));
      run_block(m, eff_np(t_sel), 2, 1'b1);
    end
    wait_drain("drain_stall");
    stall_en = 1'b0;

    // Reset during parity, then a clean block
    m.delete(); m.push_back(8'h5A); m.push_back(8'h33);
    run_block(m, 16, 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    m.delete(); m.push_back(8'hC4); m.push_back(8'h01); m.push_back(8'h9E);
    run_block(m, 16, 0, 1'b1);
    wait_drain("drain_reset");

`ifdef RS_PUNCTURE_EN
    t_sel = 5'd4;
    m.delete(); m.push_back(8'h01);
    run_block(m, eff_np(t_sel), 0, 1'b1);
    t_sel = 5'd0;
    m.delete(); m.push_back(8'h77); m.push_back(8'h12);
    run_block(m, eff_np(t_sel), 0, 1'b1);
    t_sel = 5'd20;
    m.delete(); m.push_back(8'hA5);
    run_block(m, eff_np(t_sel), 0, 1'b1);
    t_sel = 5'd8;
    wait_drain("drain_punct");
`endif

    check("len_err_total", 32'(len_err_cnt), 32'd1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
